// File: rtl/stream_demux.sv
// Registered 1-to-CHANNELS valid/ready stream demultiplexer with a per-channel buffer.
// Define STREAM_DEMUX_SKID_EN for 2-deep channel buffers with in_ready decoupled from out_ready.
module stream_demux #(
  parameter int WIDTH    = 1,
  parameter int SIZE     = 1,
  parameter int CHANNELS = 2**SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SIZE-1:0]           in_sel,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data
);

  logic                push;
  logic [CHANNELS-1:0] push_ch;
  logic [CHANNELS-1:0] pop_ch;
  logic [CHANNELS-1:0] vld_p0;
  logic [CHANNELS-1:0] vld_nxt;
  logic [WIDTH-1:0]    head_p0 [CHANNELS];

  assign push = in_valid && in_ready;

  always_comb begin
    push_ch = '0;
    if (push) push_ch[in_sel] = 1'b1;
    pop_ch = vld_p0 & out_ready;
  end

`ifdef STREAM_DEMUX_SKID_EN
  logic [1:0]       cnt_p0  [CHANNELS];
  logic [1:0]       cnt_nxt [CHANNELS];
  logic [WIDTH-1:0] tail_p0 [CHANNELS];

  // Ready looks only at registered occupancy, so no out_ready -> in_ready path.
  assign in_ready = (cnt_p0[in_sel] != 2'd2);

  always_comb begin
    cnt_nxt = cnt_p0;
    vld_nxt = vld_p0;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({push_ch[i], pop_ch[i]})
        2'b10:   cnt_nxt[i] = cnt_p0[i] + 2'd1;
        2'b01:   cnt_nxt[i] = cnt_p0[i] - 2'd1;
        default: cnt_nxt[i] = cnt_p0[i];
      endcase
      vld_nxt[i] = (cnt_nxt[i] != 2'd0);
    end
  end

  // ---- stage p0: channel control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_p0[i] <= 2'd0;
    end else begin
      vld_p0 <= vld_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end

  // Head takes the new word when it would otherwise be the only entry; tail only when
  // the word queues behind a head that stays.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push_ch[i] && ((cnt_p0[i] == 2'd0) || ((cnt_p0[i] == 2'd1) && pop_ch[i])))
        head_p0[i] <= in_data;
      else if (pop_ch[i] && (cnt_p0[i] == 2'd2))
        head_p0[i] <= tail_p0[i];
      if (push_ch[i] && (cnt_p0[i] == 2'd1) && !pop_ch[i])
        tail_p0[i] <= in_data;
    end
  end
`else
  // A full channel can still take a word in the cycle its consumer drains it.
  assign in_ready = !vld_p0[in_sel] || out_ready[in_sel];

  always_comb begin
    vld_nxt = vld_p0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (push_ch[i])     vld_nxt[i] = 1'b1;
      else if (pop_ch[i]) vld_nxt[i] = 1'b0;
    end
  end

  // ---- stage p0: channel control state ----
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= '0;
    else     vld_p0 <= vld_nxt;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push_ch[i]) head_p0[i] <= in_data;
    end
  end
`endif

  assign out_valid = vld_p0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign out_data[g*WIDTH +: WIDTH] = head_p0[g];
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (WIDTH=8, SIZE=2) against a queue-based channel model.
module tb_stream_demux;

  localparam int W = 8;
  localparam int S = 2;
  localparam int C = 4;
`ifdef STREAM_DEMUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [S-1:0] in_sel;
  logic [C-1:0] out_valid;
  logic [C-1:0] out_ready;
  logic [C*W-1:0] out_data;

  int errors = 0;
  int checks = 0;

  typedef logic [W-1:0] word_q_t[$];
  word_q_t q[C];

  stream_demux #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Model readiness: a channel can take a word if it has room, or (single-entry
  // buffer only) if its consumer takes the stored word in the same cycle.
  function automatic logic m_ready();
    int n;
    n = q[in_sel].size();
`ifdef STREAM_DEMUX_SKID_EN
    return n < DEPTH;
`else
    return (n < DEPTH) || out_ready[in_sel];
`endif
  endfunction

  task automatic tick();
    logic acc;
    logic [C-1:0] pops;
    acc = in_valid && m_ready();
    for (int c = 0; c < C; c++) pops[c] = (q[c].size() != 0) && out_ready[c];
    @(posedge clk);
    for (int c = 0; c < C; c++) if (pops[c]) void'(q[c].pop_front());
    if (acc) q[in_sel].push_back(in_data);
    if (rst) for (int c = 0; c < C; c++) q[c].delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
    end
    for (int s = 0; s < C; s++) begin
      in_sel = s[S-1:0]; #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; #1;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 4'b0100 || out_data[2*W +: W] !== 8'hA5) begin
      errors++; $display("FAIL load_ch2 got=%b/%h exp=0100/a5", out_valid, out_data[2*W +: W]);
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; #1;
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_flush got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_routing();
    logic [W-1:0] words [C];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    out_ready = 4'b1111;
    for (int k = 0; k < C; k++) begin
      in_valid = 1'b1; in_sel = k[S-1:0]; in_data = words[k]; #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL route_ready ch=%0d got=%b exp=1", k, in_ready);
      end
      tick();
      in_valid = 1'b0; #1;
      checks++;
      if (out_valid !== (4'b0001 << k) || out_data[k*W +: W] !== words[k]) begin
        errors++;
        $display("FAIL route_out ch=%0d got=%b/%h exp=%b/%h", k, out_valid,
                 out_data[k*W +: W], 4'b0001 << k, words[k]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL route_drain got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_isolation();
    int accepted;
    logic [W-1:0] ch1_words [2];
    ch1_words[0] = 8'h10; ch1_words[1] = 8'h20;
    out_ready = 4'b1101;
    accepted = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = ch1_words[k]; #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL iso_ch1_ready word=%0d got=%b exp=%b", k, in_ready, m_ready());
      end
      if (in_ready) accepted++;
      tick();
    end
    #1;
    checks++;
    if (in_ready !== 1'b0 || accepted != DEPTH) begin
      errors++; $display("FAIL iso_ch1_full got=%b/%0d exp=0/%0d", in_ready, accepted, DEPTH);
    end
    in_sel = 2'd3; in_data = 8'h30; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL iso_ch3_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 4'b1010 || out_data[3*W +: W] !== 8'h30 || out_data[1*W +: W] !== 8'h10) begin
      errors++;
      $display("FAIL iso_out got=%b/%h/%h exp=1010/30/10", out_valid,
               out_data[3*W +: W], out_data[1*W +: W]);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0010) begin
      errors++; $display("FAIL iso_ch3_delivered got=%b exp=0010", out_valid);
    end
    out_ready = 4'b1111;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[1*W +: W] !== ch1_words[k]) begin
        errors++;
        $display("FAIL iso_ch1_drain k=%0d got=%b/%h exp=1/%h", k, out_valid[1],
                 out_data[1*W +: W], ch1_words[k]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL iso_empty got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] seen[$];
    int bubbles;
    bubbles = 0;
    out_ready = 4'b0100;
    in_sel = 2'd2;
    for (int cyc = 0; cyc < 18; cyc++) begin
      in_valid = (cyc < 16);
      in_data = cyc[W-1:0];
      #1;
      if (cyc < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready cyc=%0d got=%b exp=1", cyc, in_ready);
        end
      end
      if (out_valid[2] && out_ready[2]) seen.push_back(out_data[2*W +: W]);
      else if (cyc >= 1 && cyc <= 16) bubbles++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (seen.size() != 16 || bubbles != 0) begin
      errors++; $display("FAIL stream_count got=%0d/%0d exp=16/0", seen.size(), bubbles);
    end
    for (int i = 0; i < seen.size() && i < 16; i++) begin
      checks++;
      if (seen[i] !== i[W-1:0]) begin
        errors++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, seen[i], i[W-1:0]);
      end
    end
  endtask

  task automatic test_push_pop();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01; #1;
    tick();
`ifdef STREAM_DEMUX_SKID_EN
    in_data = 8'h03; #1;
    tick();
    out_ready = 4'b0001; in_data = 8'h02; #1;
    checks++;
    if (in_ready !== m_ready()) begin
      errors++; $display("FAIL pp_full_ready got=%b exp=%b", in_ready, m_ready());
    end
    in_valid = 1'b0; tick();
    in_valid = 1'b1; #1;
    checks++;
    if (in_ready !== m_ready()) begin
      errors++; $display("FAIL pp_partial_ready got=%b exp=%b", in_ready, m_ready());
    end
    tick();
    in_valid = 1'b0; out_ready = 4'b0000; #1;
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[W-1:0] !== q[0][0]) begin
      errors++; $display("FAIL pp_head got=%b/%h exp=1/%h", out_valid[0], out_data[W-1:0], q[0][0]);
    end
`else
    out_ready = 4'b0001; in_data = 8'h02; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid[0] !== 1'b1 || out_data[W-1:0] !== 8'h01) begin
      errors++;
      $display("FAIL pp_before got=%b/%b/%h exp=1/1/01", in_ready, out_valid[0], out_data[W-1:0]);
    end
    tick();
    in_valid = 1'b0; out_ready = 4'b0000; #1;
    checks++;
    if (out_valid !== 4'b0001 || out_data[W-1:0] !== 8'h02) begin
      errors++; $display("FAIL pp_after got=%b/%h exp=0001/02", out_valid, out_data[W-1:0]);
    end
`endif
    out_ready = 4'b1111;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    int dut_acc;
    int model_acc;
    out_ready = 4'b0000;
    in_sel = 2'd0; in_valid = 1'b1; in_data = 8'h55; #1;
    while (m_ready()) begin
      tick(); in_data = in_data + 8'h01; #1;
    end
    in_data = 8'h66; #1;
    dut_acc = 0; model_acc = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b exp=0", cyc, in_ready);
      end
      if (in_ready) dut_acc++;
      tick();
    end
    out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 4 && model_acc == 0; cyc++) begin
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL bp_release cyc=%0d got=%b exp=%b", cyc, in_ready, m_ready());
      end
      if (in_ready) dut_acc++;
      if (m_ready()) model_acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (dut_acc != 1 || model_acc != 1) begin
      errors++; $display("FAIL bp_once got=%0d exp=1", dut_acc);
    end
    out_ready = 4'b0000; #1;
    checks++;
    if (out_valid[0] !== 1'b1 || q[0].size() == 0 || q[0][q[0].size()-1] !== 8'h66) begin
      errors++; $display("FAIL bp_word got=%b exp=1 with 66 queued", out_valid[0]);
    end
    out_ready = 4'b1111;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel = S'($urandom_range(0, C-1));
        in_data = W'($urandom);
      end
      out_ready = C'($urandom);
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_ready());
      end
      for (int c = 0; c < C; c++) begin
        checks++;
        if (out_valid[c] !== (q[c].size() != 0)) begin
          errors++;
          $display("FAIL rnd_valid cyc=%0d ch=%0d got=%b exp=%b", cyc, c, out_valid[c], q[c].size() != 0);
        end else if (q[c].size() != 0 && out_data[c*W +: W] !== q[c][0]) begin
          errors++;
          $display("FAIL rnd_data cyc=%0d ch=%0d got=%h exp=%h", cyc, c, out_data[c*W +: W], q[c][0]);
        end
      end
      hold = in_valid && !m_ready();
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_isolation();
    test_streaming();
    test_push_pop();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
